clint: RTL and testbench

Core-local interruptor for the small CPU: a memory-mapped slave on the cpu's unified memory bus (`memory_valid/addr/wdata/wstrb/rdata/ready`) that implements `msip`, `mtime` and `mtimecmp`, and drives the cpu's `soft_irpt` and `timer_irpt` inputs. It sits downstream of the cpu arbiter, behind the system address decode, in parallel with RAM and other peripherals.

---
 rtl/wires_pkg.sv | 33 +++
 rtl/clint_timer.sv | 76 +++++++
 rtl/clint.sv | 166 ++++++++++++++++
 tb/tb_clint.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wires_pkg.sv
// Shared definitions for the core-local interruptor (CLINT): register
// offsets within the 64 KiB window, the bus FSM state type and a
// byte-lane merge helper used by every byte-writable register.
package wires;

   // Word offsets from the CLINT base address
   localparam logic [15:0] CLINT_MSIP        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   // Bus slave handshake state
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } clint_state_type;

   // Replace each byte lane whose strobe bit is set, keep the others
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] result;
      result = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            result[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/clint_timer.sv
// CLINT free-running 64-bit mtime counter with a byte-masked write port.
// Optional feature macro: CLINT_PRESCALER_EN -- when defined, mtime only
// advances once every PRESCALE clock cycles; otherwise it advances every
// cycle and PRESCALE has no effect.
module clint_timer #(
   parameter int unsigned PRESCALE = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [63:0] mtime
);

   import wires::*;

   logic        tick;
   logic [63:0] mtime_q;
   logic [63:0] mtime_d;

`ifdef CLINT_PRESCALER_EN
   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] pre_cnt_q;
   logic [CNT_W-1:0] pre_cnt_d;

   // Prescaler counts 0..PRESCALE-1 and ticks on the wrap; writes to mtime
   // deliberately leave it alone so software cannot stretch a tick period
   always_comb begin
      tick      = (pre_cnt_q == CNT_MAX);
      pre_cnt_d = tick ? '0 : pre_cnt_q + CNT_W'(1);
   end

   // Prescaler count register
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end
`else
   logic unused_prescale;

   assign tick            = 1'b1;
   assign unused_prescale = ^PRESCALE;
`endif

   // A write to either half wins over the increment for that cycle; the
   // unwritten bytes hold their old value and no carry is propagated
   always_comb begin
      mtime_d = mtime_q;
      if (we_lo) begin
         mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata, wstrb);
      end else if (we_hi) begin
         mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata, wstrb);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   // mtime register, wraps naturally from all-ones to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q <= '0;
      end else begin
         mtime_q <= mtime_d;
      end
   end

   assign mtime = mtime_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped msip / mtimecmp / mtime block on
// the CPU's unified memory bus, driving the software and timer interrupts.
// Optional feature macro: CLINT_PRESCALER_EN (mtime tick divider, see
// clint_timer).
module clint #(
   parameter logic [31:0]  BASE_ADDR = 32'h0200_0000,
   parameter int unsigned  PRESCALE  = 100
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        memory_valid,
   input  logic        memory_instr,
   input  logic [31:0] memory_addr,
   input  logic [31:0] memory_wdata,
   input  logic [3:0]  memory_wstrb,
   output logic [31:0] memory_rdata,
   output logic        memory_ready,
   output logic        timer_irpt,
   output logic        soft_irpt
);

   import wires::*;

   clint_state_type state_q;
   clint_state_type state_d;

   logic        sel;
   logic        capture;
   logic        is_write;
   logic [15:0] offset;
   logic        we_lo;
   logic        we_hi;
   logic [31:0] read_val;
   logic [63:0] mtime;

   logic        msip_q;
   logic        msip_d;
   logic [63:0] mtimecmp_q;
   logic [63:0] mtimecmp_d;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;
   logic        ready_q;
   logic        ready_d;
   logic        timer_irpt_q;
   logic        timer_irpt_d;

   logic        unused_bits;

   // Instruction fetches are serviced as reads and the byte offset within
   // a word is irrelevant, so these inputs carry no information here
   assign unused_bits = ^{memory_instr, memory_addr[1:0]};

   // Window decode; a request is only taken while idle so RESP never
   // samples the bus and the master sees one transaction per two cycles
   always_comb begin
      offset   = {memory_addr[15:2], 2'b00};
      sel      = memory_valid && (memory_addr[31:16] == BASE_ADDR[31:16]);
      capture  = (state_q == IDLE) && sel;
      is_write = (memory_wstrb != 4'b0000);
      we_lo    = capture && is_write && (offset == CLINT_MTIME_LO);
      we_hi    = capture && is_write && (offset == CLINT_MTIME_HI);
   end

   // Read mux of the register values as they stand at the capture edge
   always_comb begin
      read_val = 32'h0000_0000;
      case (offset)
         CLINT_MSIP:        read_val = {31'd0, msip_q};
         CLINT_MTIMECMP_LO: read_val = mtimecmp_q[31:0];
         CLINT_MTIMECMP_HI: read_val = mtimecmp_q[63:32];
         CLINT_MTIME_LO:    read_val = mtime[31:0];
         CLINT_MTIME_HI:    read_val = mtime[63:32];
         default:           read_val = 32'h0000_0000;
      endcase
   end

   // Two-state handshake; rdata is only non-zero alongside the ready pulse
   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      rdata_d = 32'h0000_0000;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d = RESP;
               ready_d = 1'b1;
               rdata_d = read_val;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Byte-masked updates of msip and mtimecmp; unmapped offsets are
   // acknowledged by the FSM but change nothing
   always_comb begin
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
      if (capture && is_write) begin
         case (offset)
            CLINT_MSIP: begin
               if (memory_wstrb[0]) begin
                  msip_d = memory_wdata[0];
               end
            end
            CLINT_MTIMECMP_LO: begin
               mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], memory_wdata, memory_wstrb);
            end
            CLINT_MTIMECMP_HI: begin
               mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], memory_wdata, memory_wstrb);
            end
            default: begin
               msip_d = msip_q;
            end
         endcase
      end
   end

   // Compare uses the current registers, so the interrupt trails any
   // mtime or mtimecmp change by one edge
   always_comb begin
      timer_irpt_d = (mtime >= mtimecmp_q);
   end

   // All bus-visible state; a reset edge discards any request seen with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         rdata_q      <= 32'h0000_0000;
         msip_q       <= 1'b0;
         mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
         timer_irpt_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         rdata_q      <= rdata_d;
         msip_q       <= msip_d;
         mtimecmp_q   <= mtimecmp_d;
         timer_irpt_q <= timer_irpt_d;
      end
   end

   clint_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .we_lo (we_lo),
      .we_hi (we_hi),
      .wstrb (memory_wstrb),
      .wdata (memory_wdata),
      .mtime (mtime)
   );

   assign memory_ready = ready_q;
   assign memory_rdata = rdata_q;
   assign timer_irpt   = timer_irpt_q;
   assign soft_irpt    = msip_q;

endmodule

// File: tb/tb_clint.sv
// Directed testbench for the CLINT bus slave, timer and interrupts.
// Optional feature macro: CLINT_PRESCALER_EN (bench then uses PRESCALE=4).
module tb_clint;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk;
   logic        rst;
   logic        memory_valid;
   logic        memory_instr;
   logic [31:0] memory_addr;
   logic [31:0] memory_wdata;
   logic [3:0]  memory_wstrb;
   logic [31:0] memory_rdata;
   logic        memory_ready;
   logic        timer_irpt;
   logic        soft_irpt;

   int errors = 0;
   int checks = 0;

`ifdef CLINT_PRESCALER_EN
   clint #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
`else
   clint #(.BASE_ADDR(BASE)) dut (
`endif
      .rst          (rst),
      .clk          (clk),
      .memory_valid (memory_valid),
      .memory_instr (memory_instr),
      .memory_addr  (memory_addr),
      .memory_wdata (memory_wdata),
      .memory_wstrb (memory_wstrb),
      .memory_rdata (memory_rdata),
      .memory_ready (memory_ready),
      .timer_irpt   (timer_irpt),
      .soft_irpt    (soft_irpt)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges the sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // One bus transaction, waiting out the previous RESP cycle first;
   // lat is the number of edges until ready (99 if it never came)
   task automatic bus(input logic [15:0] off, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output int lat);
      @(posedge clk); #1;
      memory_valid = 1'b1;
      memory_addr  = BASE | {16'h0000, off};
      memory_wdata = wd;
      memory_wstrb = ws;
      lat = 99;
      rd  = 32'h0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (memory_ready) begin
            lat = i;
            rd  = memory_rdata;
            break;
         end
      end
      memory_valid = 1'b0;
      memory_wstrb = 4'b0000;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      memory_valid = 1'b0;
      memory_instr = 1'b0;
      memory_addr  = 32'h0;
      memory_wdata = 32'h0;
      memory_wstrb = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (memory_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", memory_ready); end
      checks++;
      if (memory_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", memory_rdata); end
      checks++;
      if (timer_irpt !== 1'b0) begin errors++; $display("[TB] FAIL reset_timer_irpt: got %b expected 0", timer_irpt); end
      checks++;
      if (soft_irpt !== 1'b0) begin errors++; $display("[TB] FAIL reset_soft_irpt: got %b expected 0", soft_irpt); end
      rst = 1'b0;
   endtask

   task automatic test_read_mtime;
      logic [31:0] rd;
      int lat;
      // valid asserted after the 9th free-running edge, captured on the 10th
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (memory_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 0", memory_ready); end
      memory_valid = 1'b1;
      memory_addr  = BASE | 32'h0000_BFF8;
      memory_wstrb = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (memory_ready !== 1'b1) begin errors++; $display("[TB] FAIL mtime_read_ready: got %b expected 1", memory_ready); end
      checks++;
      if (memory_rdata !== 32'd9) begin errors++; $display("[TB] FAIL mtime_read_value: got %h expected 00000009", memory_rdata); end
      memory_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (memory_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_pulse_width: got %b expected 0", memory_ready); end
      checks++;
      if (memory_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rdata_idle_zero: got %h expected 00000000", memory_rdata); end
      bus(16'h4004, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("[TB] FAIL cmp_hi_latency: got %0d expected 1", lat); end
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL cmp_hi_reset: got %h expected ffffffff", rd); end
      bus(16'h4000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL cmp_lo_reset: got %h expected ffffffff", rd); end
   endtask

   task automatic test_prescaler;
      logic [31:0] rd;
      // capture on the 41st edge after release returns mtime after 40 edges
      repeat (40) @(posedge clk);
      #1;
      memory_valid = 1'b1;
      memory_addr  = BASE | 32'h0000_BFF8;
      memory_wstrb = 4'b0000;
      @(posedge clk); #1;
      rd = memory_rdata;
      memory_valid = 1'b0;
      checks++;
      if (rd !== 32'd10) begin errors++; $display("[TB] FAIL prescaled_mtime: got %h expected 0000000a", rd); end
   endtask

   task automatic test_msip;
      logic [31:0] rd;
      int lat;
      bus(16'h0000, 32'h0000_0001, 4'b1111, rd, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("[TB] FAIL msip_write_latency: got %0d expected 1", lat); end
      checks++;
      if (soft_irpt !== 1'b1) begin errors++; $display("[TB] FAIL msip_set_irpt: got %b expected 1", soft_irpt); end
      bus(16'h0000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("[TB] FAIL msip_readback: got %h expected 00000001", rd); end
      bus(16'h0000, 32'hFFFF_FFFF, 4'b1111, rd, lat);
      bus(16'h0000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("[TB] FAIL msip_upper_bits: got %h expected 00000001", rd); end
      bus(16'h0000, 32'h0, 4'b1111, rd, lat);
      checks++;
      if (soft_irpt !== 1'b0) begin errors++; $display("[TB] FAIL msip_clear_irpt: got %b expected 0", soft_irpt); end
      // lane 0 not enabled, so bit 0 must stay clear
      bus(16'h0000, 32'h0000_0001, 4'b0010, rd, lat);
      checks++;
      if (soft_irpt !== 1'b0) begin errors++; $display("[TB] FAIL msip_masked_lane: got %b expected 0", soft_irpt); end
   endtask

   task automatic test_timer_irpt;
      logic [31:0] rd;
      int lat;
      int n;
      bus(16'h4004, 32'h0, 4'b1111, rd, lat);
      bus(16'hBFF8, 32'h0, 4'b1111, rd, lat);
      bus(16'h4000, 32'h0000_0020, 4'b1111, rd, lat);
      checks++;
      if (timer_irpt !== 1'b0) begin errors++; $display("[TB] FAIL timer_irpt_early: got %b expected 0", timer_irpt); end
      // mtime was 0 two edges ago, reaches 0x20 at the 30th edge from here
      // and the interrupt follows one edge later
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (timer_irpt) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n !== 31) begin errors++; $display("[TB] FAIL timer_irpt_rise_edge: got %0d expected 31", n); end
      bus(16'h4000, 32'hFFFF_FFFF, 4'b1111, rd, lat);
      checks++;
      if (timer_irpt !== 1'b1) begin errors++; $display("[TB] FAIL timer_irpt_lag: got %b expected 1", timer_irpt); end
      @(posedge clk); #1;
      checks++;
      if (timer_irpt !== 1'b0) begin errors++; $display("[TB] FAIL timer_irpt_fall: got %b expected 0", timer_irpt); end
   endtask

   task automatic test_mtime_write;
      logic [31:0] rd;
      int lat;
      bus(16'hBFFC, 32'h0, 4'b1111, rd, lat);
      bus(16'hBFF8, 32'hFFFF_FFFF, 4'b1111, rd, lat);
      bus(16'hBFFC, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("[TB] FAIL mtime_carry_hi: got %h expected 00000001", rd); end
      bus(16'hBFF8, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h2) begin errors++; $display("[TB] FAIL mtime_carry_lo: got %h expected 00000002", rd); end
      // lo is 4 at this capture; byte 1 replaced, no increment on the write edge
      bus(16'hBFF8, 32'h0000_AB00, 4'b0010, rd, lat);
      bus(16'hBFF8, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h0000_AB05) begin errors++; $display("[TB] FAIL mtime_byte_write: got %h expected 0000ab05", rd); end
      bus(16'hBFFC, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("[TB] FAIL mtime_hi_untouched: got %h expected 00000001", rd); end
   endtask

   task automatic test_unselected;
      logic seen;
      @(posedge clk); #1;
      memory_valid = 1'b1;
      memory_addr  = 32'h8000_0000;
      memory_wdata = 32'hFFFF_FFFF;
      memory_wstrb = 4'b0000;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (memory_ready) seen = 1'b1;
      end
      memory_valid = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL unselected_ready: got %b expected 0", seen); end
   endtask

   task automatic test_unmapped;
      logic [31:0] rd;
      int lat;
      bus(16'h1000, 32'hFFFF_FFFF, 4'b1111, rd, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("[TB] FAIL unmapped_ack: got %0d expected 1", lat); end
      bus(16'h1000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd); end
      bus(16'h0000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_msip_kept: got %h expected 00000000", rd); end
      bus(16'h4000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL unmapped_cmp_kept: got %h expected ffffffff", rd); end
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd;
      int lat;
      logic [31:0] exp_mtime;
      @(posedge clk); #1;
      memory_valid = 1'b1;
      memory_addr  = BASE;
      memory_wdata = 32'h1;
      memory_wstrb = 4'b1111;
      @(posedge clk); #1;
      checks++;
      if (memory_ready !== 1'b1 || soft_irpt !== 1'b1) begin
         errors++; $display("[TB] FAIL abort_setup: got ready=%b soft=%b expected 1 1", memory_ready, soft_irpt);
      end
      rst = 1'b1;
      memory_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (memory_ready !== 1'b0 || soft_irpt !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_in_resp: got ready=%b soft=%b expected 0 0", memory_ready, soft_irpt);
      end
      // a write presented together with reset must be dropped
      memory_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (memory_ready !== 1'b0 || soft_irpt !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_write_at_reset: got ready=%b soft=%b expected 0 0", memory_ready, soft_irpt);
      end
      memory_valid = 1'b0;
      memory_wstrb = 4'b0000;
      rst = 1'b0;
`ifdef CLINT_PRESCALER_EN
      exp_mtime = 32'd0;
`else
      exp_mtime = 32'd1;
`endif
      bus(16'hBFF8, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== exp_mtime) begin errors++; $display("[TB] FAIL abort_mtime_reset: got %h expected %h", rd, exp_mtime); end
      bus(16'h4004, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL abort_cmp_hi_reset: got %h expected ffffffff", rd); end
      bus(16'h0000, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("[TB] FAIL abort_msip_reset: got %h expected 00000000", rd); end
      checks++;
      if (timer_irpt !== 1'b0) begin errors++; $display("[TB] FAIL abort_timer_irpt: got %b expected 0", timer_irpt); end
   endtask

   // Scenario sequence
   initial begin
      $display("[TB] CLINT directed test start");
      test_reset;
`ifdef CLINT_PRESCALER_EN
      test_prescaler;
      test_msip;
`else
      test_read_mtime;
      test_msip;
      test_timer_irpt;
      test_mtime_write;
`endif
      test_unselected;
      test_unmapped;
      test_reset_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
